fetch_address_unit: RTL



---
 rtl/fetch_address_unit_if.sv | 22 ++
 rtl/fetch_address_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_address_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port and decode valid/ready port.
// master = fetch_address_unit side, slave = memory/decode side.
interface fetch_address_unit_if;
    logic        memReq;
    logic [23:0] memAdr;
    logic        memAck;
    logic [23:0] memData;
    logic        instrValid;
    logic        instrReady;
    logic [23:0] instrData;
    logic [23:0] instrAdr;

    modport master (
        output memReq, memAdr, instrValid, instrData, instrAdr,
        input  memAck, memData, instrReady
    );

    modport slave (
        input  memReq, memAdr, instrValid, instrData, instrAdr,
        output memAck, memData, instrReady
    );
endinterface

// File: rtl/fetch_address_unit.sv
// CPU24 PC / instruction-fetch sequencer with branch redirect, stall and wrap detection.
// Optional macro FETCH_WRAP_TRAP_EN: a wrapping fetch parks the unit in HALT until redirect.
module Incrementer (
    input  logic [23:0] a,
    output logic [23:0] s,
    output logic        outC
);
    assign {outC, s} = {1'b0, a} + 25'd1;
endmodule

module fetch_address_unit #(
    parameter logic [23:0] RESET_ADR = 24'h000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                redirect,
    input  logic [0:23]         redirectAdr,
    output logic                wrapFlag,
    fetch_address_unit_if.master bus
);

`ifdef FETCH_WRAP_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, DELIVER, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;
`endif

    state_t      state, state_next;
    logic [23:0] pc, pc_next;
    logic [23:0] pc_inc;
    logic        carry;
    logic        mem_req, mem_req_next;
    logic        instr_valid, instr_valid_next;
    logic [23:0] instr_data, instr_data_next;
    logic [23:0] instr_adr, instr_adr_next;
    logic        wrap_flag, wrap_flag_next;
    logic        fire;
`ifdef FETCH_WRAP_TRAP_EN
    logic        trap_pending, trap_pending_next;
`endif

    Incrementer u_inc (
        .a    (pc),
        .s    (pc_inc),
        .outC (carry)
    );

    assign fire           = (state == FETCH) && mem_req && bus.memAck;
    assign bus.memReq     = mem_req;
    assign bus.memAdr     = pc;
    assign bus.instrValid = instr_valid;
    assign bus.instrData  = instr_data;
    assign bus.instrAdr   = instr_adr;
    assign wrapFlag       = wrap_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_ADR;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            instr_data  <= 24'h000000;
            instr_adr   <= 24'h000000;
            wrap_flag   <= 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
            trap_pending <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            mem_req     <= mem_req_next;
            instr_valid <= instr_valid_next;
            instr_data  <= instr_data_next;
            instr_adr   <= instr_adr_next;
            wrap_flag   <= wrap_flag_next;
`ifdef FETCH_WRAP_TRAP_EN
            trap_pending <= trap_pending_next;
`endif
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_valid_next = instr_valid;
        instr_data_next  = instr_data;
        instr_adr_next   = instr_adr;
        wrap_flag_next   = wrap_flag;
`ifdef FETCH_WRAP_TRAP_EN
        trap_pending_next = trap_pending;
`endif

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next = redirectAdr;
                end
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (fire) begin
                    instr_data_next  = bus.memData;
                    instr_adr_next   = pc;
                    instr_valid_next = 1'b1;
                    pc_next          = pc_inc;
                    state_next       = DELIVER;
                    if (carry) begin
                        wrap_flag_next = 1'b1;
                    end
`ifdef FETCH_WRAP_TRAP_EN
                    trap_pending_next = carry;
`endif
                end
            end
            DELIVER: begin
                if (instr_valid && bus.instrReady) begin
                    instr_valid_next = 1'b0;
                    state_next       = FETCH;
`ifdef FETCH_WRAP_TRAP_EN
                    if (trap_pending) begin
                        state_next = HALT;
                    end
                    trap_pending_next = 1'b0;
`endif
                end
            end
`ifdef FETCH_WRAP_TRAP_EN
            HALT: begin
                instr_valid_next = 1'b0;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        // Redirect outranks any capture this cycle: restore everything a memAck would have touched.
        if (redirect && (state != IDLE)) begin
            pc_next          = redirectAdr;
            instr_valid_next = 1'b0;
            instr_data_next  = instr_data;
            instr_adr_next   = instr_adr;
            wrap_flag_next   = wrap_flag;
            state_next       = FETCH;
`ifdef FETCH_WRAP_TRAP_EN
            trap_pending_next = 1'b0;
`endif
        end

        mem_req_next = (state_next == FETCH) && !stall;
    end

endmodule
